// File: rtl/lc_dco_cap_bank_ctrl_if.sv
// Request channel into the LC-DCO cap-bank controller: a binary target code
// on a valid/ready handshake.
interface lc_dco_cap_bank_ctrl_if #(
   parameter int CODE_W = 5
) ();
   logic              req_valid;
   logic [CODE_W-1:0] req_code;
   logic              req_ready;

   modport master (output req_valid, output req_code, input req_ready);
   modport slave  (input req_valid, input req_code, output req_ready);
endinterface

// File: rtl/lc_dco_cap_bank_ctrl.sv
// Walks the thermometer-coded swcap drive one cell at a time toward a requested
// code, dwelling between steps. Optional step counter: define LCDCO_STEP_CNT_EN.
module lc_dco_cap_bank_ctrl #(
   parameter int N_CELLS     = 16,
   parameter int CODE_W      = 5,
   parameter int STEP_CYCLES = 4,
   parameter int RESET_CODE  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   lc_dco_cap_bank_ctrl_if.slave req,
   output logic [N_CELLS-1:0]   sw,
   output logic [CODE_W-1:0]    cur_code,
   output logic                 busy,
   output logic                 done
`ifdef LCDCO_STEP_CNT_EN
   ,
   output logic [15:0]          step_cnt
`endif
);

   localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, STEP, DWELL} state_t;

   state_t            state_q, state_d;
   logic [CODE_W-1:0] target_q, target_d;
   logic [CODE_W-1:0] cur_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              done_d;
   logic [CODE_W-1:0] req_clamped;

   function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] c);
      if (32'(c) > 32'(N_CELLS)) return CODE_W'(N_CELLS);
      return c;
   endfunction

   function automatic logic [N_CELLS-1:0] thermo(input logic [CODE_W-1:0] c);
      logic [N_CELLS-1:0] t;
      for (int i = 0; i < N_CELLS; i++) t[i] = (32'(c) > 32'(i));
      return t;
   endfunction

   assign req_clamped = clamp_code(req.req_code);

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cur_d    = cur_code;
      timer_d  = timer_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req.req_valid) begin
               target_d = req_clamped;
               if (req_clamped == cur_code) done_d  = 1'b1;
               else                         state_d = STEP;
            end
         end
         STEP: begin
            cur_d = (target_q > cur_code) ? cur_code + CODE_W'(1) : cur_code - CODE_W'(1);
            if (cur_d == target_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (STEP_CYCLES == 1) begin
               state_d = STEP;
            end else begin
               timer_d = TMR_W'(STEP_CYCLES - 1);
               state_d = DWELL;
            end
         end
         DWELL: begin
            // The timer holds the remaining dwell cycles including this one.
            timer_d = timer_q - TMR_W'(1);
            if (timer_d == '0) state_d = STEP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         target_q      <= CODE_W'(RESET_CODE);
         timer_q       <= '0;
         cur_code      <= CODE_W'(RESET_CODE);
         sw            <= thermo(CODE_W'(RESET_CODE));
         busy          <= 1'b0;
         done          <= 1'b0;
         req.req_ready <= 1'b1;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         timer_q       <= timer_d;
         cur_code      <= cur_d;
         sw            <= thermo(cur_d);
         busy          <= (state_d != IDLE);
         done          <= done_d;
         req.req_ready <= (state_d == IDLE);
      end
   end

`ifdef LCDCO_STEP_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)                                         step_cnt <= '0;
      else if (state_q == STEP && step_cnt != 16'hFFFF)  step_cnt <= step_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_lc_dco_cap_bank_ctrl.sv
// Randomized bench for lc_dco_cap_bank_ctrl against a timing-formula model.
// Define LCDCO_STEP_CNT_EN to also cover the step counter.
module tb_lc_dco_cap_bank_ctrl;
   localparam int N  = 16;
   localparam int CW = 5;
   localparam int S  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lc_dco_cap_bank_ctrl_if #(.CODE_W(CW)) bus ();
   logic [N-1:0]  sw;
   logic [CW-1:0] cur_code;
   logic          busy, done;
`ifdef LCDCO_STEP_CNT_EN
   logic [15:0]   step_cnt;
`endif

   lc_dco_cap_bank_ctrl #(.N_CELLS(N), .CODE_W(CW), .STEP_CYCLES(S), .RESET_CODE(0)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (bus),
      .sw       (sw),
      .cur_code (cur_code),
      .busy     (busy),
      .done     (done)
`ifdef LCDCO_STEP_CNT_EN
      ,
      .step_cnt (step_cnt)
`endif
   );

   int total = 0, bad = 0;

   // Model: a walk is described by start, distance, direction and accept cycle;
   // position at any later cycle follows from the dwell period alone.
   int   cyc = 0, m_cur = 0, m_start = 0, m_dist = 0, m_dir = 0, m_acc_cyc = 0, m_steps = 0;
   bit   m_walk = 0, m_done = 0, last_acc = 0, prev_ok = 0;
   logic [N-1:0] prev_sw;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      bit rst_now, acc;
      int k, st, prev_cur, c, tgt;
      logic [N-1:0] exp_sw;
      rst_now  = reset;
      acc      = bus.req_valid && !m_walk;
      c        = int'(bus.req_code);
      prev_cur = m_cur;
      @(posedge clk);
      #1;
      cyc++;
      last_acc = 0;
      m_done   = 0;
      if (rst_now) begin
         m_cur = 0; m_walk = 0; m_steps = 0;
      end else if (acc) begin
         last_acc  = 1;
         tgt       = (c > N) ? N : c;
         m_start   = m_cur;
         m_dist    = (tgt > m_cur) ? tgt - m_cur : m_cur - tgt;
         m_dir     = (tgt > m_cur) ? 1 : -1;
         m_acc_cyc = cyc;
         if (m_dist == 0) m_done = 1;
         else             m_walk = 1;
      end else if (m_walk) begin
         k  = cyc - m_acc_cyc;
         st = (k - 1) / S + 1;
         if (st > m_dist) st = m_dist;
         m_cur = m_start + m_dir * st;
         if (st == m_dist) begin
            m_walk = 0;
            m_done = 1;
         end
      end
      if (!rst_now && m_cur != prev_cur && m_steps < 65535) m_steps++;
      exp_sw = N'((33'd1 << m_cur) - 33'd1);
      chk("sw", 32'(sw), 32'(exp_sw));
      chk("cur_code", 32'(cur_code), 32'(m_cur));
      chk("busy", 32'(busy), 32'(m_walk));
      chk("done", 32'(done), 32'(m_done));
      chk("req_ready", 32'(bus.req_ready), 32'(!m_walk));
      if (!rst_now && prev_ok && sw !== prev_sw)
         chk("onehot", 32'($countones(sw ^ prev_sw)), 32'd1);
`ifdef LCDCO_STEP_CNT_EN
      chk("step_cnt", 32'(step_cnt), 32'(m_steps));
`endif
      prev_sw = sw;
      prev_ok = 1;
   endtask

   task automatic wait_accept();
      last_acc = 0;
      for (int i = 0; i < 400 && !last_acc; i++) tick();
      if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && m_walk; i++) tick();
      if (m_walk) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic req(input int code);
      bus.req_valid = 1'b1;
      bus.req_code  = CW'(code);
      wait_accept();
      bus.req_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_code  = '0;
      tick(); tick();
      reset = 1'b0;
      chk("reset_sw", 32'(sw), 32'h0);
      chk("reset_ready", 32'(bus.req_ready), 32'd1);

      // Directed walk up to 3, then clamp of 20 to full scale.
      req(3);  wait_idle(); tick();
      chk("walk3_code", 32'(cur_code), 32'd3);
      req(20); wait_idle(); tick();
      chk("clamp_sw", 32'(sw), 32'hFFFF);
      // Equal request: done pulse only.
      req(16); tick(); tick();
      chk("equal_sw", 32'(sw), 32'hFFFF);

      // Held second request is only taken once the first walk ends.
      req(10);
      bus.req_valid = 1'b1;
      bus.req_code  = CW'(4);
      wait_accept();
      chk("held_accept_code", 32'(cur_code), 32'd10);
      bus.req_valid = 1'b0;
      wait_idle(); tick();

      // Reset two steps into an eight-step walk.
      reset = 1'b1; tick(); reset = 1'b0;
      req(8);
      for (int i = 0; i < 100 && m_cur < 2; i++) tick();
      bus.req_valid = 1'b1;
      bus.req_code  = CW'(1);
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      bus.req_valid = 1'b0;
      chk("abort_sw", 32'(sw), 32'h0);
      chk("abort_busy", 32'(busy), 32'd0);
      tick();

`ifdef LCDCO_STEP_CNT_EN
      req(5); wait_idle();
      req(2); wait_idle(); tick();
      chk("step_cnt_0_5_2", 32'(step_cnt), 32'd8);
`endif

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.req_valid = 1'b1;
            bus.req_code  = CW'($urandom_range(0, 31));
            wait_accept();
            bus.req_code  = CW'($urandom_range(0, 31));
            wait_accept();
            bus.req_valid = 1'b0;
         end else begin
            req($urandom_range(0, 31));
         end
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 6)) tick();
            reset = 1'b1; tick(); reset = 1'b0;
         end else begin
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
         end
      end
      wait_idle(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
